// File: rtl/count_evt_pkg.sv
// Shared types for the count event monitor: event codes and the queued event record.
package count_evt_pkg;

  localparam int unsigned EVT_CODE_W = 3;
  // Widest counter the event record can carry; narrower counts are zero-extended.
  localparam int unsigned EVT_CNT_W  = 16;

  typedef enum logic [EVT_CODE_W-1:0] {
    EvtNone    = 3'd0,
    EvtOvf     = 3'd1,
    EvtUnf     = 3'd2,
    EvtHiCross = 3'd3,
    EvtLoCross = 3'd4,
    EvtDirChg  = 3'd5,
    EvtStall   = 3'd6
  } evt_code_t;

  typedef struct packed {
    evt_code_t              code;
    logic [EVT_CNT_W-1:0]   count;
  } evt_t;

endpackage

// File: rtl/count_evt_fifo.sv
// Show-ahead event FIFO with synchronous active-low reset; head reads as zero when empty.
module count_evt_fifo
  import count_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  evt_t                   wdata_i,
  input  logic                   pop_i,
  output evt_t                   rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] LevelFull = (PtrW+1)'(DEPTH);

  evt_t            mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   level_q, level_d;
  logic            do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LevelFull);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/count_event_monitor.sv
// Watches a counter's count/direction, classifies one event per cycle and queues it
// into a show-ahead FIFO drained over valid/ready.
module count_event_monitor
  import count_evt_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned HI_THRESH    = 12,
  parameter int unsigned LO_THRESH    = 3,
  parameter int unsigned STALL_CYCLES = 8,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       count,
  input  logic                   up_down,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [EVT_CODE_W-1:0]  evt_code,
  output logic [WIDTH-1:0]       evt_count,
  output logic                   evt_lost,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned StallW = $clog2(STALL_CYCLES);
  localparam logic [WIDTH-1:0]  MaxCount = '1;
  localparam logic [WIDTH-1:0]  HiTh     = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0]  LoTh     = WIDTH'(LO_THRESH);
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_CYCLES - 1);
  localparam logic [StallW-1:0] StallArm = StallW'(STALL_CYCLES - 2);

  typedef enum logic [0:0] {StPrime, StTrack} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  prev_count_q;
  logic              prev_dir_q;
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
  logic              lost_q;

  logic      ovf, unf, wrap, hi_cross, lo_cross, dir_chg, same, stall;
  logic      multi, push, pop, drop;
  evt_code_t evt_code_d;
  evt_t      push_evt, head;
  logic      fifo_full, fifo_empty;

  always_comb begin
    ovf      = (prev_count_q == MaxCount) && (count == '0) && up_down;
    unf      = (prev_count_q == '0) && (count == MaxCount) && !up_down;
    wrap     = ovf || unf;
    // Wraps jump across both thresholds; they are reported only as OVF/UNF.
    hi_cross = !wrap && (prev_count_q < HiTh) && (count >= HiTh);
    lo_cross = !wrap && (prev_count_q > LoTh) && (count <= LoTh);
    dir_chg  = (up_down != prev_dir_q);
    same     = (count == prev_count_q);
    stall    = same && (stall_cnt_q == StallArm);
    multi    = $countones({ovf, unf, hi_cross, lo_cross, dir_chg, stall}) > 1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!same) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != StallMax) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    evt_code_d = EvtNone;
    if (ovf)           evt_code_d = EvtOvf;
    else if (unf)      evt_code_d = EvtUnf;
    else if (hi_cross) evt_code_d = EvtHiCross;
    else if (lo_cross) evt_code_d = EvtLoCross;
    else if (dir_chg)  evt_code_d = EvtDirChg;
    else if (stall)    evt_code_d = EvtStall;
  end

  always_comb begin
    push_evt       = '0;
    push_evt.code  = evt_code_d;
    push_evt.count = EVT_CNT_W'(count);
  end

  assign push = (state_q == StTrack) && (evt_code_d != EvtNone);
  assign pop  = !fifo_empty && evt_ready;
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StPrime;
      prev_count_q <= '0;
      prev_dir_q   <= 1'b0;
      stall_cnt_q  <= '0;
      lost_q       <= 1'b0;
    end else begin
      prev_count_q <= count;
      prev_dir_q   <= up_down;
      case (state_q)
        StPrime: state_q <= StTrack;
        StTrack: begin
          stall_cnt_q <= stall_cnt_d;
          if (multi || drop) lost_q <= 1'b1;
        end
        default: state_q <= StPrime;
      endcase
    end
  end

  count_evt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .wdata_i (push_evt),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  logic unused_head_cnt;
  assign unused_head_cnt = ^head.count;

  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_count = head.count[WIDTH-1:0];
  assign evt_lost  = lost_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: a rule-level event model checked every cycle,
// plus literal expectations per scenario.
module tb_count_event_monitor;

  localparam int HI = 12, LO = 3, SC = 8, DEPTH = 4, MAXC = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count = 4'd0;
  logic       up_down = 1'b1;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [3:0] evt_count;
  logic       evt_lost;
  logic [2:0] fifo_level;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  count_event_monitor #(
    .WIDTH(4), .HI_THRESH(HI), .LO_THRESH(LO), .STALL_CYCLES(SC), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .up_down    (up_down),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_count  (evt_count),
    .evt_lost   (evt_lost),
    .fifo_level (fifo_level)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue entries are code*256 + count.
  int m_q[$];
  bit m_lost = 0, m_primed = 0, m_live = 0;
  int m_prev = 0, m_prevd = 0, m_run = 0;

  always @(posedge clk) begin
    int c, ev, ncand;
    bit ovf, unf, hi, lo, dir, st;
    if (!rst) begin
      m_q.delete();
      m_lost = 0;
      m_primed = 0;
      m_run = 0;
      m_live = 1;
    end else begin
      c = int'(count);
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      if (!m_primed) begin
        m_primed = 1;
        m_run = 1;
      end else begin
        ovf = (m_prev == MAXC) && (c == 0) && up_down;
        unf = (m_prev == 0) && (c == MAXC) && !up_down;
        hi  = !(ovf || unf) && (m_prev < HI) && (c >= HI);
        lo  = !(ovf || unf) && (m_prev > LO) && (c <= LO);
        dir = (int'(up_down) != m_prevd);
        m_run = (c == m_prev) ? m_run + 1 : 1;
        st  = (m_run == SC);
        ncand = int'(ovf) + int'(unf) + int'(hi) + int'(lo) + int'(dir) + int'(st);
        if (ncand > 1) m_lost = 1;
        ev = ovf ? 1 : unf ? 2 : hi ? 3 : lo ? 4 : dir ? 5 : st ? 6 : 0;
        if (ev != 0) begin
          if (m_q.size() < DEPTH) m_q.push_back(ev * 256 + c);
          else m_lost = 1;
        end
      end
      m_prev = c;
      m_prevd = int'(up_down);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("valid", int'(evt_valid), (m_q.size() > 0) ? 1 : 0);
      chk("level", int'(fifo_level), m_q.size());
      chk("code", int'(evt_code), (m_q.size() > 0) ? m_q[0] / 256 : 0);
      chk("count", int'(evt_count), (m_q.size() > 0) ? m_q[0] % 256 : 0);
      chk("lost", int'(evt_lost), int'(m_lost));
    end
  end

  // Events actually handed over by the DUT.
  int log_q[$];
  int exp_q[$];
  always @(posedge clk) begin
    if (rst && evt_valid && evt_ready) log_q.push_back(int'(evt_code) * 256 + int'(evt_count));
  end

  task automatic check_log(input string name);
    chk({name, "_n"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_%0d", name, i), (i < log_q.size()) ? log_q[i] : -1, exp_q[i]);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic cyc(input int c, input bit ud);
    count = 4'(c);
    up_down = ud;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int c, input bit ud);
    rst = 1'b0;
    count = 4'(c);
    up_down = ud;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic head(input string name, input int code, input int cnt);
    chk({name, "_valid"}, int'(evt_valid), 1);
    chk({name, "_code"}, int'(evt_code), code);
    chk({name, "_count"}, int'(evt_count), cnt);
  endtask

  initial begin
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset(0, 1'b1);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_lost", int'(evt_lost), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_count", int'(evt_count), 0);

    // 1: up-count through the wrap
    log_q.delete();
    cyc(0, 1'b1);
    for (int v = 1; v <= 15; v++) begin
      cyc(v, 1'b1);
      if (v == 11) chk("t1_pre_hi", int'(evt_valid), 0);
      if (v == 12) head("t1_hi", 3, 12);
    end
    cyc(0, 1'b1);
    head("t1_ovf", 1, 0);
    cyc(1, 1'b1);
    exp_q = '{3 * 256 + 12, 1 * 256 + 0};
    check_log("t1_log");

    // 2: down-count through 3 and the 0->15 wrap
    cyc(5, 1'b1);
    cyc(4, 1'b0);
    head("t2_dir", 5, 4);
    cyc(3, 1'b0);
    head("t2_lo", 4, 3);
    cyc(2, 1'b0);
    cyc(1, 1'b0);
    cyc(0, 1'b0);
    cyc(15, 1'b0);
    head("t2_unf", 2, 15);
    cyc(14, 1'b0);
    exp_q = '{5 * 256 + 4, 4 * 256 + 3, 2 * 256 + 15};
    check_log("t2_log");

    // 3: stalls at 7 and then at 8
    for (int i = 1; i <= 10; i++) begin
      cyc(7, 1'b0);
      if (i == 7) chk("t3_pre_stall", int'(evt_valid), 0);
      if (i == 8) head("t3_stall7", 6, 7);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(8, 1'b0);
      if (i == 7) chk("t3_pre_stall8", int'(evt_valid), 0);
      if (i == 8) head("t3_stall8", 6, 8);
    end
    cyc(9, 1'b0);
    exp_q = '{6 * 256 + 7, 6 * 256 + 8};
    check_log("t3_log");

    // 4: HI_CROSS and DIR_CHG together
    cyc(11, 1'b0);
    chk("t4_lost_before", int'(evt_lost), 0);
    cyc(12, 1'b1);
    head("t4_hi", 3, 12);
    chk("t4_lost_after", int'(evt_lost), 1);
    cyc(13, 1'b1);
    exp_q = '{3 * 256 + 12};
    check_log("t4_log");

    // 5: overfill with evt_ready low
    do_reset(0, 1'b1);
    chk("t5_rst_lost", int'(evt_lost), 0);
    cyc(0, 1'b1);
    evt_ready = 1'b0;
    cyc(1, 1'b0);
    cyc(2, 1'b1);
    cyc(3, 1'b0);
    cyc(4, 1'b1);
    chk("t5_level4", int'(fifo_level), 4);
    chk("t5_lost_full", int'(evt_lost), 0);
    cyc(5, 1'b0);
    chk("t5_level_sat", int'(fifo_level), 4);
    chk("t5_lost_drop", int'(evt_lost), 1);
    head("t5_head", 5, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc(5, 1'b0);
    chk("t5_drained", int'(fifo_level), 0);
    exp_q = '{5 * 256 + 1, 5 * 256 + 2, 5 * 256 + 3, 5 * 256 + 4};
    check_log("t5_log");

    // 6: reset with events queued, then PRIME swallows the first sample
    evt_ready = 1'b0;
    cyc(6, 1'b1);
    cyc(7, 1'b0);
    cyc(8, 1'b1);
    chk("t6_level3", int'(fifo_level), 3);
    do_reset(8, 1'b1);
    chk("t6_valid", int'(evt_valid), 0);
    chk("t6_level", int'(fifo_level), 0);
    chk("t6_lost", int'(evt_lost), 0);
    chk("t6_code", int'(evt_code), 0);
    cyc(13, 1'b0);
    chk("t6_prime", int'(evt_valid), 0);
    evt_ready = 1'b1;
    cyc(14, 1'b0);
    chk("t6_no_evt", int'(evt_valid), 0);
    cyc(2, 1'b0);
    head("t6_lo", 4, 2);
    cyc(1, 1'b0);
    exp_q = '{4 * 256 + 2};
    check_log("t6_log");

    cyc(1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
Downstream consumer of the up_down_counter output. It samples count and up_down every clock, detects wrap-around, threshold crossings, direction changes and stalls, and queues one event per cycle into a small show-ahead FIFO. The FIFO drains over a valid/ready handshake to the scoreboard or status logic.

Parameters:
WIDTH, 4, counter width; must match the counter's count port
HI_THRESH, 12, upper threshold; must be in range 1..2**WIDTH-1
LO_THRESH, 3, lower threshold; must be below HI_THRESH
STALL_CYCLES, 8, consecutive unchanged samples that raise a STALL event; must be at least 2
DEPTH, 4, event FIFO entries; must be a power of 2

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset
count  in  WIDTH  counter value
up_down  in  1  counter direction: 1 = up, 0 = down
evt_ready  in  1  consumer accepts the head event
evt_valid  out  1  FIFO not empty
evt_code  out  3  head event code
evt_count  out  WIDTH  count value that raised the head event
evt_lost  out  1  sticky flag: an event was dropped
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst==0 at a rising edge):
  - FIFO empty: evt_valid=0, fifo_level=0. evt_code=0 and evt_count=0 while the FIFO is empty.
  - evt_lost=0, stall counter=0, FSM goes to PRIME.
  - Reset mid-operation discards queued events without any handshake.
- FSM:
  - PRIME: latch prev_count and prev_dir, raise no event, then go to TRACK on the next edge.
  - TRACK: each edge compares count/up_down against prev_count/prev_dir, then updates prev_count and prev_dir.
- Event detection (TRACK only), in priority order; at most one event per cycle:
  - OVF (1): prev_count == 2**WIDTH-1, count == 0, up_down == 1.
  - UNF (2): prev_count == 0, count == 2**WIDTH-1, up_down == 0.
  - HI_CROSS (3): prev_count < HI_THRESH and count >= HI_THRESH. Not raised on a wrap cycle.
  - LO_CROSS (4): prev_count > LO_THRESH and count <= LO_THRESH. Not raised on a wrap cycle.
  - DIR_CHG (5): up_down != prev_dir.
  - STALL (6):
    - The stall counter increments while count == prev_count and clears on any change.
    - The event fires when the counter reaches STALL_CYCLES-1, i.e. on the STALL_CYCLES-th consecutive equal sample.
    - The counter then saturates, so no repeat until count changes.
  - Code 0 is reserved (NONE).
  - If several conditions hold in one cycle, only the highest priority is pushed. Each discarded lower-priority condition sets evt_lost.
- Latency: the counter changes at edge k; the monitor detects it at edge k+1. evt_valid=1 after edge k+1 if the FIFO was empty. No combinational path from count to evt_*.
- FIFO: show-ahead; evt_code and evt_count reflect the head entry.
  - Pop on evt_valid && evt_ready at the edge.
  - Push and pop in the same cycle: level unchanged; data order preserved.
  - Full with push and pop in the same cycle: push accepted.
  - Full with push and no pop: event dropped, evt_lost set.
  - Pop while empty: ignored.
- evt_lost clears only on reset.
- Arithmetic: all comparisons unsigned over WIDTH bits. Pointers wrap modulo DEPTH; fifo_level is one bit wider than the pointers.

Decomposition:
- Package count_evt_pkg holds:
  - enum evt_code_t: NONE=0, OVF, UNF, HI_CROSS, LO_CROSS, DIR_CHG, STALL.
  - struct evt_t: code, count.
  - localparam EVT_CODE_W=3.
- One sub-module, count_evt_fifo: DEPTH-entry synchronous show-ahead FIFO of evt_t with push/pop/full/empty/level and the same clk/rst.
- Detection, priority and stall logic stay in count_event_monitor.

Test Plan:
1. Up-count from 0 with evt_ready=1 through 15 -> 0 -> HI_CROSS(count=12) and OVF(count=0) each appear exactly once, each one cycle after the count change; no other events.
2. Down-count from 5 to 15 -> LO_CROSS(count=3), then UNF(count=15). No HI_CROSS on the 0->15 wrap.
3. Hold count at 7 for 10 cycles -> exactly one STALL(count=7) on the 8th equal sample; after count changes to 8 and holds for 8 more cycles, a second STALL(count=8).
4. Toggle up_down on the same edge the count goes 11->12 -> HI_CROSS pushed, DIR_CHG dropped, evt_lost=1.
5. evt_ready=0, generate 5 events -> fifo_level saturates at 4, evt_lost=1, the fifth event is lost. Raising evt_ready drains the first four in order.
6. Drive rst=0 for one edge with 3 events queued -> evt_valid=0, fifo_level=0, evt_lost=0. The first post-reset sample produces no event (PRIME).
